// File: rtl/mux_arb_n_pkg.sv
// Shared constants for the channel mux/arbiter: default widths, the
// arbitration mode encoding and a clog2 helper for sizing channel IDs.
package mux_arb_n_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_CHANNELS = 8;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

    // Ceiling log2, minimum result 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Round-robin priority search.
//   req         : per-channel request vector
//   ptr         : last granted channel; search starts at ptr+1 and wraps
//   grant       : one-hot grant (zero when nothing requests)
//   grant_idx   : index of the granted channel
//   grant_valid : any channel granted
module rr_arbiter
    import mux_arb_n_pkg::*;
#(
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned SELW     = clog2(DEFAULT_CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grant_idx,
    output logic                grant_valid
);

    // One extra bit so ptr+i (< 2*CHANNELS) cannot overflow before the wrap.
    logic [SELW:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            cand = {1'b0, ptr} + (SELW+1)'(i);
            if (cand >= (SELW+1)'(CHANNELS)) begin
                cand = cand - (SELW+1)'(CHANNELS);
            end
            if (!grant_valid && req[cand[SELW-1:0]]) begin
                grant_valid               = 1'b1;
                grant_idx                 = cand[SELW-1:0];
                grant[cand[SELW-1:0]]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel multiplexer with fixed-select or round-robin arbitration and a
// single registered output stage.
//   clock, reset_n        : clock, async active-low reset
//   mode_rr               : 0 = fixed select, 1 = round-robin
//   select                : channel used in fixed mode
//   in_valid/in_ready     : per-channel handshake (in_ready one-hot or zero)
//   in_data               : channel k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready   : output handshake
//   out_data/out_chan     : registered word and its source channel
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned SELW     = clog2(DEFAULT_CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      mode_rr,
    input  logic [SELW-1:0]           select,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready
);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_chan_q,  out_chan_d;
    logic [SELW-1:0]     ptr_q,       ptr_d;

    arb_mode_e           mode;
    logic                can_load;
    logic                sel_in_range;
    logic                transfer;
    logic [SELW-1:0]     grant_idx;
    logic [CHANNELS-1:0] rr_grant;
    logic [SELW-1:0]     rr_idx;
    logic                rr_valid;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (ptr_q),
        .grant       (rr_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    assign mode         = arb_mode_e'(mode_rr);
    assign can_load     = !out_valid_q || out_ready;
    assign sel_in_range = 32'(select) < CHANNELS;

    // Grant generation never looks at in_data.
    // Fixed mode offers ready on the selected channel only while some channel
    // is requesting, so an idle input bus always sees in_ready == 0.
    always_comb begin
        in_ready  = '0;
        grant_idx = '0;
        if (mode == MODE_RR) begin
            grant_idx = rr_idx;
            if (can_load && rr_valid) begin
                in_ready = rr_grant;
            end
        end else begin
            if (sel_in_range) begin
                grant_idx = select;
                if (can_load && (|in_valid)) begin
                    in_ready[select] = 1'b1;
                end
            end
        end
    end

    assign transfer = |(in_valid & in_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[32'(grant_idx)*WIDTH +: WIDTH];
            out_chan_d  = grant_idx;
            // Pointer only tracks round-robin grants; fixed mode leaves it alone.
            if (mode == MODE_RR) begin
                ptr_d = grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= SELW'(CHANNELS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;
    import mux_arb_n_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    // 8-channel instance
    logic         mode_rr, out_ready, out_valid;
    logic [2:0]   select, out_chan;
    logic [7:0]   in_valid, in_ready;
    logic [255:0] in_data;
    logic [31:0]  out_data;

    // 5-channel instance
    logic         mode_rr5, out_ready5, out_valid5;
    logic [2:0]   select5, out_chan5;
    logic [4:0]   in_valid5, in_ready5;
    logic [159:0] in_data5;
    logic [31:0]  out_data5;

    mux_arb_n #(.WIDTH(32), .CHANNELS(8), .SELW(3)) dut8 (
        .clock(clock), .reset_n(reset_n), .mode_rr(mode_rr), .select(select),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
    );

    mux_arb_n #(.WIDTH(32), .CHANNELS(5), .SELW(3)) dut5 (
        .clock(clock), .reset_n(reset_n), .mode_rr(mode_rr5), .select(select5),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_chan(out_chan5),
        .out_ready(out_ready5)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  chan;
        logic [31:0] data;
    } word_t;
    word_t sb[$];

    typedef struct {
        logic       rr;
        logic [2:0] sel;
        logic [7:0] iv;
        logic       ordy;
        logic [7:0] exp_rdy;
        logic       exp_ov;
    } vec8_t;

    typedef struct {
        logic       rr;
        logic [2:0] sel;
        logic [4:0] iv;
        logic [4:0] exp_rdy;
        logic       exp_ov;
        logic [2:0] exp_chan;
    } vec5_t;

    vec8_t t8[26];
    vec5_t t5[8];

    function automatic logic [31:0] d8(input int k);
        return (k == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(k));
    endfunction

    function automatic logic [31:0] d5(input int k);
        return 32'hA5A50000 | 32'(k);
    endfunction

    function automatic logic [2:0] oh_idx(input logic [7:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic vec8_t mk8(input logic rr, input logic [2:0] sel, input logic [7:0] iv,
                                 input logic ordy, input logic [7:0] er, input logic eov);
        vec8_t v;
        v.rr = rr; v.sel = sel; v.iv = iv; v.ordy = ordy; v.exp_rdy = er; v.exp_ov = eov;
        return v;
    endfunction

    function automatic vec5_t mk5(input logic rr, input logic [2:0] sel, input logic [4:0] iv,
                                  input logic [4:0] er, input logic eov, input logic [2:0] ech);
        vec5_t v;
        v.rr = rr; v.sel = sel; v.iv = iv; v.exp_rdy = er; v.exp_ov = eov; v.exp_chan = ech;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w;

        // Round-robin over all channels starting from reset pointer
        t8[0]  = mk8(1, 0, 8'hFF, 1, 8'h01, 0);
        t8[1]  = mk8(1, 0, 8'hFF, 1, 8'h02, 1);
        t8[2]  = mk8(1, 0, 8'hFF, 1, 8'h04, 1);
        t8[3]  = mk8(1, 0, 8'hFF, 1, 8'h08, 1);
        t8[4]  = mk8(1, 0, 8'hFF, 1, 8'h10, 1);
        t8[5]  = mk8(1, 0, 8'hFF, 1, 8'h20, 1);
        t8[6]  = mk8(1, 0, 8'hFF, 1, 8'h40, 1);
        t8[7]  = mk8(1, 0, 8'hFF, 1, 8'h80, 1);
        t8[8]  = mk8(1, 0, 8'hFF, 1, 8'h01, 1);
        t8[9]  = mk8(1, 0, 8'hFF, 1, 8'h02, 1);
        // Fixed select 5 with channels 0 and 5 requesting
        t8[10] = mk8(0, 5, 8'h21, 1, 8'h20, 1);
        t8[11] = mk8(0, 5, 8'h00, 1, 8'h00, 1);
        t8[12] = mk8(0, 2, 8'h04, 1, 8'h04, 0);
        t8[13] = mk8(1, 0, 8'h00, 1, 8'h00, 1);
        // Round-robin wrap: ptr=1 -> ch3 -> ch0
        t8[14] = mk8(1, 0, 8'h09, 1, 8'h08, 0);
        t8[15] = mk8(1, 0, 8'h09, 1, 8'h01, 1);
        // Backpressure for 4 cycles, with a mode switch while holding
        t8[16] = mk8(0, 6, 8'h40, 0, 8'h00, 1);
        t8[17] = mk8(1, 0, 8'hFF, 0, 8'h00, 1);
        t8[18] = mk8(1, 0, 8'hFF, 0, 8'h00, 1);
        t8[19] = mk8(0, 6, 8'h40, 0, 8'h00, 1);
        // Release: drain and load in the same cycle; fixed mode keeps ptr
        t8[20] = mk8(0, 6, 8'h40, 1, 8'h40, 1);
        t8[21] = mk8(1, 0, 8'hFF, 1, 8'h02, 1);
        t8[22] = mk8(0, 3, 8'hFF, 1, 8'h08, 1);
        t8[23] = mk8(1, 0, 8'hFF, 1, 8'h04, 1);
        t8[24] = mk8(1, 0, 8'h00, 1, 8'h00, 1);
        t8[25] = mk8(1, 0, 8'h00, 1, 8'h00, 0);

        t5[0] = mk5(1, 0, 5'b10001, 5'b00001, 0, 0);
        t5[1] = mk5(1, 0, 5'b10001, 5'b10000, 1, 0);
        t5[2] = mk5(1, 0, 5'b10001, 5'b00001, 1, 4);
        t5[3] = mk5(1, 0, 5'b10001, 5'b10000, 1, 0);
        t5[4] = mk5(0, 6, 5'b11111, 5'b00000, 1, 4);
        t5[5] = mk5(0, 6, 5'b11111, 5'b00000, 0, 0);
        t5[6] = mk5(0, 4, 5'b11111, 5'b10000, 0, 0);
        t5[7] = mk5(0, 4, 5'b00000, 5'b00000, 1, 4);

        for (int k = 0; k < 8; k++) in_data[k*32 +: 32] = d8(k);
        for (int k = 0; k < 5; k++) in_data5[k*32 +: 32] = d5(k);

        reset_n   = 1'b0;
        mode_rr   = 1'b1; select  = '0; in_valid  = '0; out_ready  = 1'b1;
        mode_rr5  = 1'b1; select5 = '0; in_valid5 = '0; out_ready5 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_chan", 64'(out_chan), 64'd0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clock);
            mode_rr   = t8[i].rr;
            select    = t8[i].sel;
            in_valid  = t8[i].iv;
            out_ready = t8[i].ordy;
            #1;
            chk($sformatf("t8[%0d] in_ready", i), 64'(in_ready), 64'(t8[i].exp_rdy));
            chk($sformatf("t8[%0d] out_valid", i), 64'(out_valid), 64'(t8[i].exp_ov));
            if (t8[i].exp_ov && t8[i].ordy) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL t8[%0d] scoreboard: got drain expected no word", i);
                end else begin
                    w = sb.pop_front();
                    chk($sformatf("t8[%0d] out_chan", i), 64'(out_chan), 64'(w.chan));
                    chk($sformatf("t8[%0d] out_data", i), 64'(out_data), 64'(w.data));
                end
            end
            if (|(t8[i].iv & t8[i].exp_rdy)) begin
                w.chan = oh_idx(t8[i].exp_rdy);
                w.data = d8(int'(oh_idx(t8[i].exp_rdy)));
                sb.push_back(w);
            end
        end
        chk("scoreboard leftover", 64'(sb.size()), 64'd0);

        // Reset while a word is held under backpressure
        @(negedge clock);
        mode_rr = 1'b1; in_valid = 8'h01; out_ready = 1'b0;
        #1;
        chk("pre-reset in_ready", 64'(in_ready), 64'h01);
        @(negedge clock);
        #1;
        chk("pre-reset out_valid", 64'(out_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'd0);
        chk("async reset out_data", 64'(out_data), 64'd0);
        chk("async reset out_chan", 64'(out_chan), 64'd0);
        @(negedge clock);
        reset_n = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        chk("post-reset first grant", 64'(in_ready), 64'h01);
        @(negedge clock);
        in_valid = 8'h00;
        #1;
        chk("post-reset out_valid", 64'(out_valid), 64'd1);
        chk("post-reset out_chan", 64'(out_chan), 64'd0);
        chk("post-reset out_data", 64'(out_data), 64'(d8(0)));
        @(negedge clock);
        #1;
        chk("post-reset drained", 64'(out_valid), 64'd0);

        // 5-channel instance: wrap at CHANNELS-1 and out-of-range select
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            mode_rr5  = t5[i].rr;
            select5   = t5[i].sel;
            in_valid5 = t5[i].iv;
            #1;
            chk($sformatf("t5[%0d] in_ready", i), 64'(in_ready5), 64'(t5[i].exp_rdy));
            chk($sformatf("t5[%0d] out_valid", i), 64'(out_valid5), 64'(t5[i].exp_ov));
            if (t5[i].exp_ov) begin
                chk($sformatf("t5[%0d] out_chan", i), 64'(out_chan5), 64'(t5[i].exp_chan));
                chk($sformatf("t5[%0d] out_data", i), 64'(out_data5), 64'(d5(int'(t5[i].exp_chan))));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
